uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  Upstream of the CPU top level. Receives a program image over UART and writes it
//  word-by-word into instruction memory through a write port.
//  Holds the CPU (cpu_hold) while a load is in progress.
//  Frame layout: 2-byte word count N (little-endian), then N 32-bit words, each little-endian.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  system clock frequency
//  BAUD         115200       UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer divide)
//  ADDR_W       14           word-address width of the instruction memory
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  uart_rx    in   1       serial input; idle high; 8N1
//  start      in   1       level; rising edge arms a load (one-cycle pulse, already debounced)
//  cpu_hold   out  1       1 from arm until DONE/ERR; CPU held in reset
//  we         out  1       one-cycle write strobe to instruction memory
//  waddr      out  ADDR_W  word address for we
//  wdata      out  32      word data for we
//  done       out  1       sticky 1 after a successful load; cleared by the next arm
//  err        out  1       sticky 1 after a failed load; cleared by the next arm
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; RX idle; counters 0. Reset mid-load aborts; no we after rst low.
//  RX: uart_rx passes through a 2-flop synchroniser.
//   - Start bit is a falling edge. It is re-checked low at CLKS_PER_BIT/2 (a glitch returns to RX idle).
//   - 8 data bits, LSB first, each sampled at its bit centre.
//   - Stop bit sampled at its centre. Stop=0 is a framing error.
//   - byte_valid pulses 1 cycle at the stop-bit sample.
//  FSM: IDLE -> HDR0 -> HDR1 -> DATA -> [CSUM] -> DONE | ERR
//   IDLE : start edge -> HDR0; cpu_hold<=1, done<=0, err<=0, waddr<=0. Bytes ignored.
//   HDR0 : byte -> cnt[7:0]. HDR1: byte -> cnt[15:8].
//          - cnt == 0 -> DONE, or CSUM when the macro is defined.
//          - cnt > 2**ADDR_W -> ERR.
//          - otherwise -> DATA.
//   DATA : bytes shift into wdata, first byte = wdata[7:0].
//          - On the 4th byte: we=1 the next cycle, with waddr/wdata stable that cycle.
//          - waddr increments after the strobe.
//          - After word N -> DONE (or CSUM).
//   DONE : done=1, cpu_hold=0. A start edge re-arms (same actions as IDLE).
//   ERR  : err=1, cpu_hold=0. A start edge re-arms.
//  A framing error in any non-IDLE state -> ERR immediately; the partial word is not written.
//  start edges while cpu_hold=1 are ignored.
//  waddr wraps only at 2**ADDR_W, which is unreachable because of the cnt check.
//  Latency: stop-bit sample of byte 4 -> we is exactly 1 cycle.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//   - The frame carries one extra trailing byte: XOR of all preceding frame bytes, header included.
//   - CSUM state compares it against a running XOR: match -> DONE, mismatch -> ERR.
//  Undefined: no CSUM state; the FSM enters DONE directly after the last word, or after the header when N=0.
// TESTING (CLK_FREQ_HZ=1_000_000, BAUD=100_000 -> 10 clks/bit)
//  1 rst low 3 cycles, then high -> all outputs 0; uart_rx toggling alone causes no we.
//  2 start; send 02 00 78 56 34 12 EF BE AD DE ->
//    - we at waddr 0 wdata 0x12345678, then at waddr 1 wdata 0xDEADBEEF;
//    - done=1, cpu_hold=0.
//  3 start; send 00 00 -> no we; done=1 (CSUM_EN: needs trailing 00 first).
//  4 start; send header 01 00, then a byte with stop bit 0 -> err=1, cpu_hold=0, no we.
//  5 start; send header, then 2 data bytes; pull rst low -> outputs 0;
//    - after release, remaining bytes cause no we.
//  6 CSUM_EN: frame 01 00 04 03 02 01 with checksum byte 05 -> done;
//    - same frame with checksum 00 -> err; we for word 0x01020304 occurs in both cases.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART 8N1 receiver feeding a framed program image into instruction memory.
// Optional trailing XOR checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module uart_prog_loader #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  input  logic              start,
  output logic              cpu_hold,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              done,
  output logic              err
);
  localparam int CPB = CLK_FREQ_HZ / BAUD;
  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [16:0] MAXW = 17'(1) << ADDR_W;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE, S_ERR
  } st_t;
`ifdef LOADER_CHECKSUM_EN
  localparam st_t FIN = S_CSUM;
`else
  localparam st_t FIN = S_DONE;
`endif
  logic rx_s1_q, rx_s2_q, rx_p_q, start_p_q;
  rx_t rs_q, rs_d;
  logic [CW-1:0] ck_q, ck_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic byte_valid, frame_err;
  st_t st_q, st_d;
  logic [7:0] lo_q, lo_d;
  logic [15:0] rem_q, rem_d, n;
  logic [1:0] bidx_q, bidx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif
  always_comb begin
    rs_d = rs_q;
    ck_d = ck_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    byte_valid = 1'b0;
    frame_err = 1'b0;
    case (rs_q)
      R_IDLE: begin
        ck_d = '0;
        if (rx_p_q && !rx_s2_q) rs_d = R_START;
      end
      R_START: if (ck_q == HALF) begin
        ck_d = '0;
        bit_d = '0;
        rs_d = rx_s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (ck_q == FULL) begin
        ck_d = '0;
        sh_d = {rx_s2_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) rs_d = R_STOP;
      end
      R_STOP: if (ck_q == FULL) begin
        byte_valid = rx_s2_q;
        frame_err = !rx_s2_q;
        rs_d = R_IDLE;
      end
      default: rs_d = R_IDLE;
    endcase
  end
  always_comb begin
    n = {sh_q, lo_q};
    st_d = st_q;
    lo_d = lo_q;
    rem_d = rem_q;
    bidx_d = bidx_q;
    wdata_d = wdata_q;
    waddr_d = we_q ? waddr_q + 1'b1 : waddr_q;
    we_d = 1'b0;
    hold_d = hold_q;
    done_d = done_q;
    err_d = err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d = byte_valid ? csum_q ^ sh_q : csum_q;
`endif
    if (start && !start_p_q && !hold_q) begin
      st_d = S_HDR0;
      hold_d = 1'b1;
      done_d = 1'b0;
      err_d = 1'b0;
      waddr_d = '0;
      bidx_d = '0;
`ifdef LOADER_CHECKSUM_EN
      csum_d = '0;
`endif
    end else if (hold_q && frame_err) begin
      st_d = S_ERR;
    end else if (byte_valid) begin
      case (st_q)
        S_HDR0: begin
          lo_d = sh_q;
          st_d = S_HDR1;
        end
        S_HDR1: begin
          rem_d = n;
          st_d = (n == 16'd0) ? FIN : ({1'b0, n} > MAXW) ? S_ERR : S_DATA;
        end
        S_DATA: begin
          wdata_d = {sh_q, wdata_q[31:8]};
          bidx_d = bidx_q + 1'b1;
          if (bidx_q == 2'd3) begin
            we_d = 1'b1;
            rem_d = rem_q - 1'b1;
            if (rem_q == 16'd1) st_d = FIN;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: st_d = (sh_q == csum_q) ? S_DONE : S_ERR;
`endif
        default: st_d = st_q;
      endcase
    end
    if (st_d == S_DONE && st_q != S_DONE) begin
      hold_d = 1'b0;
      done_d = 1'b1;
    end
    if (st_d == S_ERR && st_q != S_ERR) begin
      hold_d = 1'b0;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_p_q <= 1'b1;
      start_p_q <= 1'b0;
      rs_q <= R_IDLE;
      ck_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      st_q <= S_IDLE;
      lo_q <= '0;
      rem_q <= '0;
      bidx_q <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      we_q <= 1'b0;
      hold_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_p_q <= rx_s2_q;
      start_p_q <= start;
      rs_q <= rs_d;
      ck_q <= ck_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      st_q <= st_d;
      lo_q <= lo_d;
      rem_q <= rem_d;
      bidx_q <= bidx_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      we_q <= we_d;
      hold_q <= hold_d;
      done_q <= done_d;
      err_q <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
  assign cpu_hold = hold_q;
  assign we = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed frames over a 10 clk/bit UART line with hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_prog_loader;
  logic clk = 1'b0, rst = 1'b0, uart_rx = 1'b1, start = 1'b0;
  logic cpu_hold, we, done, err;
  logic [13:0] waddr;
  logic [31:0] wdata;
  int n_chk = 0, n_err = 0, nwe = 0;
  logic [31:0] wd[16];
  logic [13:0] wa[16];
  logic [7:0] x = 8'h00;
  always #5 clk = ~clk;
  uart_prog_loader #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .start(start), .cpu_hold(cpu_hold),
    .we(we), .waddr(waddr), .wdata(wdata), .done(done), .err(err)
  );
  always @(negedge clk) if (we) begin
    if (nwe < 16) begin
      wd[nwe] = wdata;
      wa[nwe] = waddr;
    end
    nwe++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic tx(input logic [7:0] b, input logic stp);
    x ^= b;
    uart_rx = 1'b0;
    cyc(10);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cyc(10);
    end
    uart_rx = stp;
    cyc(10);
    uart_rx = 1'b1;
    cyc(5);
  endtask
  task automatic arm();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    x = 8'h00;
  endtask
  task automatic csum();
`ifdef LOADER_CHECKSUM_EN
    tx(x, 1'b1);
`endif
    cyc(2);
  endtask
  initial begin
    cyc(3);
    @(negedge clk);
    chk("rst_ctl", {28'd0, cpu_hold, we, done, err}, 32'd0);
    chk("rst_addr", {18'd0, waddr}, 32'd0);
    chk("rst_data", wdata, 32'd0);
    rst = 1'b1;
    cyc(2);
    tx(8'hA5, 1'b1);
    tx(8'h3C, 1'b1);
    chk("idle_we", nwe, 0);
    chk("idle_ctl", {29'd0, cpu_hold, done, err}, 32'd0);
    arm();
    chk("arm_hold", {31'd0, cpu_hold}, 32'd1);
    tx(8'h02, 1'b1);
    tx(8'h00, 1'b1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    foreach (wd[i]) if (i < 0) wd[i] = 0;
    tx(8'h78, 1'b1); tx(8'h56, 1'b1); tx(8'h34, 1'b1); tx(8'h12, 1'b1);
    tx(8'hEF, 1'b1); tx(8'hBE, 1'b1); tx(8'hAD, 1'b1); tx(8'hDE, 1'b1);
    csum();
    chk("two_nwe", nwe, 2);
    chk("w0_addr", {18'd0, wa[0]}, 32'd0);
    chk("w0_data", wd[0], 32'h12345678);
    chk("w1_addr", {18'd0, wa[1]}, 32'd1);
    chk("w1_data", wd[1], 32'hDEADBEEF);
    chk("two_ctl", {29'd0, cpu_hold, done, err}, 32'b010);
    arm();
    chk("rearm_ctl", {29'd0, cpu_hold, done, err}, 32'b100);
    tx(8'h00, 1'b1);
    tx(8'h00, 1'b1);
    csum();
    chk("zero_nwe", nwe, 2);
    chk("zero_ctl", {29'd0, cpu_hold, done, err}, 32'b010);
    arm();
    tx(8'h01, 1'b1);
    tx(8'h00, 1'b1);
    tx(8'h11, 1'b0);
    cyc(2);
    chk("frm_ctl", {29'd0, cpu_hold, done, err}, 32'b001);
    chk("frm_nwe", nwe, 2);
    arm();
    tx(8'h03, 1'b1); tx(8'h00, 1'b1);
    tx(8'h44, 1'b1); tx(8'h33, 1'b1); tx(8'h22, 1'b1); tx(8'h11, 1'b1);
    tx(8'h66, 1'b1); tx(8'h55, 1'b1);
    chk("abort_nwe", nwe, 3);
    chk("abort_w0", wd[2], 32'h11223344);
    chk("abort_addr", {18'd0, waddr}, 32'd1);
    chk("abort_hold", {31'd0, cpu_hold}, 32'd1);
    rst = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("abort_ctl", {28'd0, cpu_hold, we, done, err}, 32'd0);
    chk("abort_waddr0", {18'd0, waddr}, 32'd0);
    chk("abort_wdata0", wdata, 32'd0);
    rst = 1'b1;
    cyc(2);
    tx(8'h88, 1'b1); tx(8'h77, 1'b1); tx(8'h44, 1'b1); tx(8'h33, 1'b1);
    tx(8'h22, 1'b1); tx(8'h11, 1'b1); tx(8'h00, 1'b1); tx(8'h99, 1'b1);
    cyc(2);
    chk("post_nwe", nwe, 3);
    chk("post_ctl", {29'd0, cpu_hold, done, err}, 32'd0);
    arm();
    tx(8'h01, 1'b1);
    tx(8'h40, 1'b1);
    cyc(2);
    chk("big_ctl", {29'd0, cpu_hold, done, err}, 32'b001);
    arm();
    tx(8'h00, 1'b1);
    tx(8'h40, 1'b1);
    cyc(2);
    chk("max_ctl", {29'd0, cpu_hold, done, err}, 32'b100);
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(2);
`ifdef LOADER_CHECKSUM_EN
    arm();
    tx(8'h01, 1'b1); tx(8'h00, 1'b1);
    tx(8'h04, 1'b1); tx(8'h03, 1'b1); tx(8'h02, 1'b1); tx(8'h01, 1'b1);
    tx(8'h05, 1'b1);
    cyc(2);
    chk("cs_ok_ctl", {29'd0, cpu_hold, done, err}, 32'b010);
    chk("cs_ok_nwe", nwe, 4);
    chk("cs_ok_data", wd[3], 32'h01020304);
    arm();
    tx(8'h01, 1'b1); tx(8'h00, 1'b1);
    tx(8'h04, 1'b1); tx(8'h03, 1'b1); tx(8'h02, 1'b1); tx(8'h01, 1'b1);
    tx(8'h00, 1'b1);
    cyc(2);
    chk("cs_bad_ctl", {29'd0, cpu_hold, done, err}, 32'b001);
    chk("cs_bad_nwe", nwe, 5);
    chk("cs_bad_data", wd[4], 32'h01020304);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
